hex_display_driver: RTL and testbench
=====================================

HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

Interface
REQ-001 Parameter DIGITS, default 4: number of hex digits driven, legal 1..8.
REQ-002 Parameter BLINK_DIV, default 25_000_000: clock cycles per blink half-period, legal >= 2.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 Port load, input, 1: capture strobe for value.
REQ-006 Port value, input, 4*DIGITS: nibble i at [4i+3:4i]; digit 0 is least significant.
REQ-007 Port blank, input, 1: force all digits off while high.
REQ-008 Port lz_en, input, 1: leading-zero suppression enable.
REQ-009 Port blink_mask, input, DIGITS: bit i high makes digit i blink.
REQ-010 Port hex_seg, output, 7*DIGITS: digit i at [7i+6:7i], segment order a..g MSB to LSB, active-low.
REQ-011 Port blink_phase, output, 1: current blink phase; 1 means visible.

Function
REQ-012 value_q (4*DIGITS register) SHALL capture value on every edge where load=1, otherwise hold.
REQ-013 hex_seg SHALL be registered from value_q and the current control inputs, giving 2-edge latency from load sampled to new pattern on hex_seg.
REQ-014 blank, lz_en and blink_mask SHALL affect hex_seg 1 edge after they are sampled.
REQ-015 Per-nibble encoding a..g: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
REQ-016 Encoding continued: 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-017 A blanked digit SHALL output 1111111.
REQ-018 Blink counter SHALL count 0..BLINK_DIV-1 and wrap to 0.
REQ-019 blink_phase SHALL toggle on the edge where the counter wraps.
REQ-020 Digit i SHALL be blanked when blink_mask[i]=1 and blink_phase=0.
REQ-021 An edge with load=1 SHALL clear the counter to 0 and set blink_phase=1, so a new value is shown at once.
REQ-022 With lz_en=1, digit i (i>0) SHALL be blanked iff nibbles i..DIGITS-1 of value_q are all 0.
REQ-023 Digit 0 SHALL never be suppressed by lz_en; value_q=0 displays a single "0".
REQ-024 Blank precedence: reset, then blank, then blink, then leading-zero suppression, then encoding.
REQ-025 When DIGITS=1, lz_en SHALL have no effect.

Reset
REQ-026 On an edge with reset_n=0: value_q=0, counter=0, blink_phase=1, every hex_seg field=1111111.
REQ-027 Reset SHALL override a load sampled on the same edge.
REQ-028 Reset asserted mid-blink SHALL restart the blink sequence from phase 1, counter 0.
REQ-029 The first edge with reset_n=1 SHALL compute hex_seg from value_q=0: digit fields 0000001, or digits 1..DIGITS-1 blank if lz_en=1.

Verification
REQ-030 The bench SHALL use DIGITS=4 and BLINK_DIV=4, and SHALL cover the scenarios REQ-031 to REQ-036.
REQ-031 Encoding and latency: after reset, load value=16'h1A2F at edge N -> hex_seg at edge N+2 = 1001111_0001000_0010010_0111000; the hex_seg value just before edge N+2 is still the reset-derived pattern.
REQ-032 All 16 nibbles: load 16'h0123, 16'h4567, 16'h89AB and 16'hCDEF in turn -> every field matches REQ-015/REQ-016.
REQ-033 Leading zeros: lz_en=1, load 16'h0040 -> fields 3..0 = 1111111, 1111111, 1001100, 0000001; load 16'h0000 -> only digit 0 shows 0000001.
REQ-034 Blink: blink_mask=4'b0001, value 16'h1234, no loads -> blink_phase toggles every 4 cycles; digit 0 alternates 1001100 / 1111111 with a 4-cycle half-period; digits 1..3 steady.
REQ-035 Load during blink: load while blink_phase=0 -> blink_phase=1 on the next edge, counter=0, and the new digit is visible for a full 4-cycle half-period.
REQ-036 Precedence and reset: blank=1 with blink and lz_en active -> all fields 1111111. reset_n=0 with load=1 on the same edge -> value_q=0, blink_phase=1, hex_seg all ones.

Source files
------------

// File: rtl/hex_display_driver.sv
// Multi-digit hex to 7-segment driver with blanking, blink and leading-zero suppression.
// Segment fields are active-low, a..g from MSB to LSB, and updated once per clock.
module hex_display_driver #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank,
    input  logic                  lz_en,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   hex_seg,
    output logic                  blink_phase
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    logic [4*DIGITS-1:0] value_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                phase_q;
    logic [7*DIGITS-1:0] seg_q;
    logic [7*DIGITS-1:0] seg_d;
    logic [DIGITS-1:0]   lz_blank;
    logic                zero_run;

    function automatic logic [6:0] encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0001100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // A digit is a leading zero when it and every more significant nibble are zero.
    // Digit 0 is never included, so a zero value still shows one "0".
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            zero_run    = zero_run & (value_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end
    end

    always_comb begin
        seg_d = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (blank) begin
                seg_d[7*i +: 7] = SEG_OFF;
            end else if (blink_mask[i] && !phase_q) begin
                seg_d[7*i +: 7] = SEG_OFF;
            end else if (lz_en && lz_blank[i]) begin
                seg_d[7*i +: 7] = SEG_OFF;
            end else begin
                seg_d[7*i +: 7] = encode(value_q[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            seg_q   <= '1;
        end else begin
            seg_q <= seg_d;
            // A fresh load restarts the blink so the new value is visible immediately.
            if (load) begin
                value_q <= value;
                cnt_q   <= '0;
                phase_q <= 1'b1;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign hex_seg     = seg_q;
    assign blink_phase = phase_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver (DIGITS=4, BLINK_DIV=4) with a per-cycle
// reference model plus literal pattern checks.
module tb_hex_display_driver;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [15:0] value;
    logic        blank;
    logic        lz_en;
    logic [3:0]  blink_mask;
    logic [27:0] hex_seg;
    logic        blink_phase;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_value = '0;
    int          m_k     = 0;
    logic        m_phase = 1'b1;
    logic [27:0] m_seg   = '1;
    logic        m_valid = 1'b0;

    logic [6:0] enc_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [15:0] vec_val [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [27:0] vec_seg [4] = '{
        28'b0000001_1001111_0010010_0000110,
        28'b1001100_0100100_0100000_0001111,
        28'b0000000_0001100_0001000_1100000,
        28'b0110001_1000010_0110000_0111000
    };

    hex_display_driver #(
        .DIGITS    (4),
        .BLINK_DIV (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .value       (value),
        .blank       (blank),
        .lz_en       (lz_en),
        .blink_mask  (blink_mask),
        .hex_seg     (hex_seg),
        .blink_phase (blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    // Display pattern from the rules: blank > blink > leading zero > encoding.
    function automatic logic [27:0] model_seg(input logic [15:0] v, input logic bl,
                                              input logic lz, input logic [3:0] mk,
                                              input logic ph);
        logic [27:0] r;
        logic [15:0] upper;
        r = '1;
        for (int i = 0; i < 4; i++) begin
            upper = v >> (4 * i);
            if (bl) r[7*i +: 7] = 7'h7F;
            else if (mk[i] && !ph) r[7*i +: 7] = 7'h7F;
            else if (lz && i > 0 && upper == 16'h0) r[7*i +: 7] = 7'h7F;
            else r[7*i +: 7] = enc_tab[upper[3:0]];
        end
        return r;
    endfunction

    // Advance the model over one edge using the inputs now applied, then compare.
    task automatic step();
        logic [27:0] nxt;
        nxt = !reset_n ? 28'hFFFFFFF : model_seg(m_value, blank, lz_en, blink_mask, m_phase);
        if (!reset_n) begin
            m_value = '0;
            m_k     = 0;
            m_valid = 1'b1;
        end else if (load) begin
            m_value = value;
            m_k     = 0;
        end else begin
            m_k++;
        end
        // Phase is 1 for the first half-period after a restart, then alternates.
        m_phase = ((m_k / 4) % 2) == 0;
        m_seg   = nxt;
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("model_hex_seg", hex_seg, m_seg);
            chk("model_blink_phase", {27'b0, blink_phase}, {27'b0, m_phase});
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
        step();
    endtask

    initial begin
        reset_n    = 1'b0;
        load       = 1'b0;
        value      = '0;
        blank      = 1'b0;
        lz_en      = 1'b0;
        blink_mask = '0;
        step();
        step();
        chk("reset_seg", hex_seg, 28'hFFFFFFF);
        chk("reset_phase", {27'b0, blink_phase}, 28'd1);

        reset_n = 1'b1;
        step();
        chk("first_after_reset", hex_seg, {4{7'b0000001}});

        value = 16'h1A2F;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk("latency_before", hex_seg, {4{7'b0000001}});
        step();
        chk("latency_after", hex_seg, 28'b1001111_0001000_0010010_0111000);

        for (int j = 0; j < 4; j++) begin
            do_load(vec_val[j]);
            chk("all_nibbles", hex_seg, vec_seg[j]);
        end

        lz_en = 1'b1;
        do_load(16'h0040);
        chk("lz_0040", hex_seg, 28'b1111111_1111111_1001100_0000001);
        do_load(16'h0000);
        chk("lz_0000", hex_seg, 28'b1111111_1111111_1111111_0000001);
        lz_en = 1'b0;

        blink_mask = 4'b0001;
        do_load(16'h1234);
        step();
        step();
        step();
        chk("blink_phase_low", {27'b0, blink_phase}, 28'd0);
        step();
        chk("blink_digit0_off", hex_seg, 28'b1001111_0010010_0000110_1111111);
        for (int j = 0; j < 8; j++) step();
        chk("blink_phase_before_load", {27'b0, blink_phase}, 28'd0);

        value = 16'h5678;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk("load_restarts_phase", {27'b0, blink_phase}, 28'd1);
        for (int j = 0; j < 4; j++) step();
        chk("new_digit_full_half", hex_seg, 28'b0100100_0100000_0001111_0000000);
        for (int j = 0; j < 6; j++) step();

        lz_en      = 1'b1;
        blink_mask = 4'hF;
        blank      = 1'b1;
        step();
        chk("blank_precedence", hex_seg, 28'hFFFFFFF);
        blank = 1'b0;
        step();
        step();

        reset_n = 1'b0;
        load    = 1'b1;
        value   = 16'hFFFF;
        step();
        chk("reset_over_load_seg", hex_seg, 28'hFFFFFFF);
        chk("reset_over_load_phase", {27'b0, blink_phase}, 28'd1);
        reset_n    = 1'b1;
        load       = 1'b0;
        lz_en      = 1'b0;
        blink_mask = 4'b0000;
        step();
        chk("reset_cleared_value", hex_seg, {4{7'b0000001}});
        for (int j = 0; j < 6; j++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
